mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 19 +
 rtl/mux_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexed scan controller.
package mux_scan_pkg;

    localparam int CH_W  = 4;
    localparam int N_CH  = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    // Next channel in the scan order; 15 wraps back to 0.
    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] ch);
        return ch + CH_W'(1);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 16:1 mux: steps sel through a channel
// window, waits SETTLE_CYC cycles per channel, samples mux_out and publishes
// the assembled frame with a one-cycle valid pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            cont,
    input  logic [CH_W-1:0] first_ch,
    input  logic [CH_W-1:0] last_ch,
    output logic [CH_W-1:0] sel,
    input  logic            mux_out,
    output logic [N_CH-1:0] data,
    output logic            valid,
    output logic            busy
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CH_W-1:0]   first_q, first_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [N_CH-1:0]   shadow_q, shadow_d;
    logic [N_CH-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   merged;

    // Next-state and output computation for the IDLE/SETTLE/SAMPLE sequencer.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        first_d  = first_q;
        last_d   = last_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        merged   = shadow_q;
        merged[sel_q] = mux_out;

        case (state_q)
            ST_IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    first_d  = first_ch;
                    last_d   = last_ch;
                    sel_d    = first_ch;
                    shadow_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sel_q != last_q) begin
                    shadow_d = merged;
                    sel_d    = ch_inc(sel_q);
                    state_d  = ST_SETTLE;
                end else begin
                    // frame complete: publish, then re-arm on the latched window or stop
                    data_d  = merged;
                    valid_d = 1'b1;
                    if (cont) begin
                        sel_d    = first_q;
                        shadow_d = '0;
                        cnt_d    = '0;
                        state_d  = ST_SETTLE;
                    end else begin
                        shadow_d = merged;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            first_q  <= '0;
            last_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            first_q  <= first_d;
            last_q   <= last_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sel   = sel_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (settle 1 and 3) against a
// channel-index/cycle-count reference model, plus directed literal checks.
module tb_mux_scan_ctrl;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cont = 1'b0;
    logic [3:0]  first_ch = 4'd0;
    logic [3:0]  last_ch = 4'd0;
    logic [15:0] mux_in = 16'd0;

    logic [3:0]  sel0, sel1;
    logic [15:0] data0, data1;
    logic        valid0, valid1, busy0, busy1, mo0, mo1;

    assign mo0 = mux_in[sel0];
    assign mo1 = mux_in[sel1];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.SETTLE_CYC(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
        .first_ch(first_ch), .last_ch(last_ch), .sel(sel0), .mux_out(mo0),
        .data(data0), .valid(valid0), .busy(busy0)
    );

    mux_scan_ctrl #(.SETTLE_CYC(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
        .first_ch(first_ch), .last_ch(last_ch), .sel(sel1), .mux_out(mo1),
        .data(data1), .valid(valid1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int edge_no = 0;
    int t0 = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: scan position k within the window, cycle c within a channel.
    bit          m_act[2];
    int          m_k[2];
    int          m_c[2];
    logic [3:0]  m_first[2];
    logic [3:0]  m_last[2];
    logic [3:0]  m_sel[2];
    logic [15:0] m_frame[2];
    logic [15:0] m_data[2];
    bit          m_valid[2];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int s;
            int n;
            s = (i == 0) ? S0 : S1;
            m_valid[i] = 1'b0;
            if (!rst_n) begin
                m_act[i] = 1'b0; m_k[i] = 0; m_c[i] = 0; m_sel[i] = 4'd0;
                m_frame[i] = 16'd0; m_data[i] = 16'd0; m_first[i] = 4'd0; m_last[i] = 4'd0;
            end else if (!m_act[i]) begin
                if (start && !abort) begin
                    m_act[i] = 1'b1; m_first[i] = first_ch; m_last[i] = last_ch;
                    m_k[i] = 0; m_c[i] = 0; m_frame[i] = 16'd0; m_sel[i] = first_ch;
                end
            end else if (abort) begin
                m_act[i] = 1'b0;
            end else if (m_c[i] < s) begin
                m_c[i]++;
            end else begin
                m_frame[i][m_sel[i]] = mux_in[m_sel[i]];
                n = ((int'(m_last[i]) - int'(m_first[i]) + 16) % 16) + 1;
                if (m_k[i] == n - 1) begin
                    m_data[i] = m_frame[i];
                    m_valid[i] = 1'b1;
                    if (cont) begin
                        m_k[i] = 0; m_c[i] = 0; m_frame[i] = 16'd0; m_sel[i] = m_first[i];
                    end else begin
                        m_act[i] = 1'b0;
                    end
                end else begin
                    m_k[i]++;
                    m_c[i] = 0;
                    m_sel[i] = 4'((int'(m_first[i]) + m_k[i]) % 16);
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic cmp(input int i, input logic [3:0] s, input logic [15:0] d,
                       input logic v, input logic b);
        check($sformatf("sel%0d", i), 32'(s), 32'(m_sel[i]));
        check($sformatf("data%0d", i), 32'(d), 32'(m_data[i]));
        check($sformatf("valid%0d", i), 32'(v), 32'(m_valid[i]));
        check($sformatf("busy%0d", i), 32'(b), 32'(m_act[i]));
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, sel0, data0, valid0, busy0);
            cmp(1, sel1, data1, valid1, busy1);
        end
    end

    function automatic bit vld(input int i);
        return (i == 0) ? valid0 : valid1;
    endfunction

    function automatic bit bsy(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction

    // start high for exactly one edge; t0 is that edge's number
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = edge_no;
    endtask

    // latency in edges from t0 to the edge that raised valid, -1 on timeout
    task automatic wait_valid(input int i, input int limit, output int lat, output bit dropped);
        lat = -1;
        dropped = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (vld(i)) begin
                lat = edge_no - t0;
                return;
            end
            if (!bsy(i)) dropped = 1'b1;
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (!busy0 && !busy1) return;
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int  lat;
        bit  dropped;
        int  nv;
        logic [3:0] sq [8];

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_sel", 32'(sel0), 32'd0);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;

        // full window, pattern A5C3
        mux_in = 16'hA5C3; first_ch = 4'd0; last_ch = 4'd15;
        pulse_start();
        wait_valid(0, 200, lat, dropped);
        check("full_lat", 32'(lat), 32'd32);
        check("full_data", 32'(data0), 32'hA5C3);
        check("full_busy_after", 32'(busy0), 32'd0);
        @(negedge clk);
        check("full_pulse_once", 32'(valid0), 32'd0);
        wait_valid(1, 200, lat, dropped);
        check("full_lat_s3", 32'(lat), 32'd64);
        check("full_data_s3", 32'(data1), 32'hA5C3);
        wait_idle(50);

        // partial window 4..7
        mux_in = 16'hFFFF; first_ch = 4'd4; last_ch = 4'd7;
        pulse_start();
        wait_valid(0, 100, lat, dropped);
        check("win_lat", 32'(lat), 32'd8);
        check("win_data", 32'(data0), 32'h00F0);
        wait_valid(1, 100, lat, dropped);
        check("win_lat_s3", 32'(lat), 32'd16);
        check("win_data_s3", 32'(data1), 32'h00F0);
        wait_idle(50);

        // wrapping window 14..1
        first_ch = 4'd14; last_ch = 4'd1;
        pulse_start();
        sq[0] = sel0;
        for (int n = 1; n < 7; n++) begin
            @(negedge clk);
            sq[n] = sel0;
        end
        check("wrap_sel0", 32'(sq[0]), 32'd14);
        check("wrap_sel1", 32'(sq[2]), 32'd15);
        check("wrap_sel2", 32'(sq[4]), 32'd0);
        check("wrap_sel3", 32'(sq[6]), 32'd1);
        wait_valid(0, 100, lat, dropped);
        check("wrap_lat", 32'(lat), 32'd8);
        check("wrap_data", 32'(data0), 32'hC003);
        wait_idle(100);

        // ignored start while busy, abort at edge 10, start+abort together at edge 11
        mux_in = 16'hA5C3; first_ch = 4'd0; last_ch = 4'd15;
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1; first_ch = 4'd3; last_ch = 4'd5;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_mid", 32'(busy0), 32'd1);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_data", 32'(data0), 32'hC003);
        check("abort_sel", 32'(sel0), 32'd4);
        check("abort_novalid", 32'(valid0), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("startabort_busy", 32'(busy0), 32'd0);
        nv = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (valid0 || valid1 || busy0 || busy1) nv++;
        end
        check("abort_quiet", 32'(nv), 32'd0);

        // continuous mode across a pattern change
        cont = 1'b1; mux_in = 16'h1234; first_ch = 4'd0; last_ch = 4'd15;
        pulse_start();
        wait_valid(0, 100, lat, dropped);
        check("cont_lat1", 32'(lat), 32'd32);
        check("cont_data1", 32'(data0), 32'h1234);
        check("cont_busy1", 32'(dropped), 32'd0);
        mux_in = 16'h8001;
        t0 = edge_no;
        wait_valid(0, 100, lat, dropped);
        check("cont_lat2", 32'(lat), 32'd32);
        check("cont_data2", 32'(data0), 32'h8001);
        check("cont_busy2", 32'(dropped), 32'd0);
        cont = 1'b0;
        wait_idle(300);

        // reset for one edge mid-scan
        mux_in = 16'h5A5A;
        pulse_start();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_sel", 32'(sel0), 32'd0);
        check("mrst_data", 32'(data0), 32'd0);
        check("mrst_valid", 32'(valid0), 32'd0);
        check("mrst_busy", 32'(busy0), 32'd0);
        nv = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (valid0 || valid1) nv++;
        end
        check("mrst_novalid", 32'(nv), 32'd0);

        // randomized traffic, checked every cycle by the model
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 31) == 0) cont = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                first_ch = 4'($urandom);
                last_ch = 4'($urandom);
            end
            if ($urandom_range(0, 9) == 0) mux_in = 16'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
